// File: rtl/ldpc_ber_sequencer.sv
// Autonomous multi-frame BER test controller: PRBS message generation, error injection,
// decoder sequencing with timeout, and saturating frame/fail/bit-error/timeout statistics.
module ldpc_ber_sequencer #(
    parameter int MM    = 168,
    parameter int NN    = 208,
    parameter int CNT_W = 32,
    parameter int TO_W  = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [31:0]      seed,
    input  logic [NN-1:0]    err_base,
    input  logic [TO_W-1:0]  dec_timeout,
    output logic [NN-MM-1:0] msg_o,
    input  logic             enc_valid_i,
    input  logic [NN-1:0]    enc_cword_i,
    output logic [NN-1:0]    q0_0_o,
    output logic [NN-1:0]    q0_1_o,
    output logic             dec_start_o,
    input  logic             dec_done_i,
    input  logic             dec_pass_i,
    input  logic [NN-1:0]    dec_word_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [2:0]       state_o
);

    localparam int KK = NN - MM;
    localparam int LW = $clog2(KK);
    localparam int PW = $clog2(NN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ENC_WAIT  = 3'd2,
        S_INJECT    = 3'd3,
        S_DEC_START = 3'd4,
        S_DEC_WAIT  = 3'd5,
        S_CHECK     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [KK-1:0]    msg_q, msg_d;
    logic [NN-1:0]    err_q, err_d;
    logic [NN-1:0]    cword_q, cword_d;
    logic [NN-1:0]    q00_q, q00_d;
    logic [NN-1:0]    q01_q, q01_d;
    logic             dec_start_q, dec_start_d;
    logic [TO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic [LW-1:0]    load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] biterr_q, biterr_d;
    logic [CNT_W-1:0] tmocnt_q, tmocnt_d;

    logic             start_edge;
    logic             busy_w;
    logic             pass_w;
    logic [CNT_W-1:0] frame_new;
    logic [PW-1:0]    err_bits;
    logic [CNT_W:0]   biterr_sum;

    function automatic logic [PW-1:0] popcount(input logic [NN-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NN; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign start_edge = start & ~start_q;
    assign busy_w     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign pass_w     = ~tmo_q & dec_pass_i & (dec_word_i == cword_q);
    assign frame_new  = sat_inc(frame_q);
    assign err_bits   = tmo_q ? PW'(NN) : popcount(dec_word_i ^ cword_q);
    assign biterr_sum = {1'b0, biterr_q} + (CNT_W + 1)'(err_bits);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        msg_d      = msg_q;
        err_d      = err_q;
        cword_d    = cword_q;
        q00_d      = q00_q;
        q01_d      = q01_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_d      = tmo_q;
        load_cnt_d = load_cnt_q;
        frame_d    = frame_q;
        fail_d     = fail_q;
        biterr_d   = biterr_q;
        tmocnt_d   = tmocnt_q;

        // Abort discards the in-flight frame: no counter or datapath updates.
        if (busy_w && abort) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        frame_d    = '0;
                        fail_d     = '0;
                        biterr_d   = '0;
                        tmocnt_d   = '0;
                        lfsr_d     = (seed == 32'h0) ? 32'h1 : seed;
                        err_d      = (mode == 2'd1 || mode == 2'd2) ? err_base : '0;
                        load_cnt_d = '0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    msg_d      = {msg_q[KK-2:0], lfsr_q[0]};
                    lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
                    load_cnt_d = load_cnt_q + LW'(1);
                    if (load_cnt_q == LW'(KK - 1)) state_d = S_ENC_WAIT;
                end
                S_ENC_WAIT: begin
                    if (enc_valid_i) begin
                        cword_d = enc_cword_i;
                        state_d = S_INJECT;
                    end
                end
                S_INJECT: begin
                    q00_d   = '1;
                    q01_d   = cword_q ^ err_q;
                    state_d = S_DEC_START;
                end
                S_DEC_START: begin
                    tmo_cnt_d = '0;
                    state_d   = S_DEC_WAIT;
                end
                S_DEC_WAIT: begin
                    tmo_cnt_d = tmo_cnt_q + TO_W'(1);
                    if (dec_done_i) begin
                        tmo_d   = 1'b0;
                        state_d = S_CHECK;
                    end else if (tmo_cnt_d == dec_timeout) begin
                        tmo_d   = 1'b1;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    frame_d  = frame_new;
                    if (!pass_w) fail_d = sat_inc(fail_q);
                    if (tmo_q) tmocnt_d = sat_inc(tmocnt_q);
                    biterr_d = biterr_sum[CNT_W] ? '1 : biterr_sum[CNT_W-1:0];
                    if (mode == 2'd2) err_d = {err_q[NN-2:0], err_q[NN-1]};
                    if (num_frames != '0 && frame_new == num_frames) begin
                        state_d = S_DONE;
                    end else begin
                        load_cnt_d = '0;
                        state_d    = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        dec_start_d = (state_d == S_DEC_START);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            lfsr_q      <= '0;
            msg_q       <= '0;
            err_q       <= '0;
            cword_q     <= '0;
            q00_q       <= '0;
            q01_q       <= '0;
            dec_start_q <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_q       <= 1'b0;
            load_cnt_q  <= '0;
            frame_q     <= '0;
            fail_q      <= '0;
            biterr_q    <= '0;
            tmocnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            lfsr_q      <= lfsr_d;
            msg_q       <= msg_d;
            err_q       <= err_d;
            cword_q     <= cword_d;
            q00_q       <= q00_d;
            q01_q       <= q01_d;
            dec_start_q <= dec_start_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_q       <= tmo_d;
            load_cnt_q  <= load_cnt_d;
            frame_q     <= frame_d;
            fail_q      <= fail_d;
            biterr_q    <= biterr_d;
            tmocnt_q    <= tmocnt_d;
        end
    end

    assign msg_o       = msg_q;
    assign q0_0_o      = q00_q;
    assign q0_1_o      = q01_q;
    assign dec_start_o = dec_start_q;
    assign busy        = busy_w;
    assign done        = (state_q == S_DONE);
    assign frame_cnt   = frame_q;
    assign fail_cnt    = fail_q;
    assign bit_err_cnt = biterr_q;
    assign timeout_cnt = tmocnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ldpc_ber_sequencer.sv
// Bench for ldpc_ber_sequencer: encoder/decoder behavioural models plus a scoreboard of
// expected injected decoder inputs, checked on every decoder start pulse.
module tb_ldpc_ber_sequencer;

    localparam int MM    = 168;
    localparam int NN    = 208;
    localparam int KK    = NN - MM;
    localparam int CNT_W = 32;
    localparam int TO_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_frames;
    logic [31:0]      seed;
    logic [NN-1:0]    err_base;
    logic [TO_W-1:0]  dec_timeout;
    logic [KK-1:0]    msg_o;
    logic             enc_valid_i;
    logic [NN-1:0]    enc_cword_i;
    logic [NN-1:0]    q0_0_o, q0_1_o;
    logic             dec_start_o;
    logic             dec_done_i, dec_pass_i;
    logic [NN-1:0]    dec_word_i;
    logic             busy, done;
    logic [CNT_W-1:0] frame_cnt, fail_cnt, bit_err_cnt, timeout_cnt;
    logic [2:0]       state_o;

    logic             done_en;
    logic             echo_q0;

    int               checks   = 0;
    int               failures = 0;
    int               pulses   = 0;
    logic             prev_ds  = 1'b0;
    logic [NN-1:0]    exp_q[$];
    logic [NN-1:0]    mon_exp;
    logic [KK-1:0]    first_msg;

    always #5 clk = ~clk;

    function automatic logic [NN-1:0] enc_model(input logic [KK-1:0] m);
        return {m, {4{m}}, m[7:0]};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    assign enc_valid_i = 1'b1;
    assign enc_cword_i = enc_model(msg_o);
    assign dec_done_i  = done_en;
    assign dec_pass_i  = 1'b1;
    assign dec_word_i  = echo_q0 ? q0_1_o : enc_cword_i;

    ldpc_ber_sequencer #(.MM(MM), .NN(NN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .mode(mode),
        .num_frames(num_frames), .seed(seed), .err_base(err_base), .dec_timeout(dec_timeout),
        .msg_o(msg_o), .enc_valid_i(enc_valid_i), .enc_cword_i(enc_cword_i),
        .q0_0_o(q0_0_o), .q0_1_o(q0_1_o), .dec_start_o(dec_start_o),
        .dec_done_i(dec_done_i), .dec_pass_i(dec_pass_i), .dec_word_i(dec_word_i),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .fail_cnt(fail_cnt),
        .bit_err_cnt(bit_err_cnt), .timeout_cnt(timeout_cnt), .state_o(state_o)
    );

    // Scoreboard: every decoder start must present the next expected injected word.
    always @(negedge clk) begin
        if (dec_start_o === 1'b1) begin
            pulses++;
            checks++;
            if (prev_ds !== 1'b0) begin
                failures++;
                $display("FAIL dec_start_width: prev=%b required=0", prev_ds);
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: unexpected dec_start, required none");
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (q0_1_o !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_q0_1: got=%h required=%h", q0_1_o, mon_exp);
                end
                checks++;
                if (q0_0_o !== {NN{1'b1}}) begin
                    failures++;
                    $display("FAIL sb_q0_0: got=%h required=all ones", q0_0_o);
                end
            end
        end
        prev_ds = dec_start_o;
    end

    task automatic push_frames(input logic [31:0] sd, input logic [1:0] md,
                               input logic [NN-1:0] eb, input int n);
        logic [31:0]   l;
        logic [KK-1:0] m;
        logic [NN-1:0] e;
        l = (sd == 32'h0) ? 32'h1 : sd;
        m = '0;
        e = (md == 2'd1 || md == 2'd2) ? eb : '0;
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < KK; i++) begin
                m = {m[KK-2:0], l[0]};
                l = lfsr_step(l);
            end
            if (f == 0) first_msg = m;
            exp_q.push_back(enc_model(m) ^ e);
            if (md == 2'd2) e = {e[NN-2:0], e[NN-1]};
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: done=%b required=1 within %0d cycles", tag, done, maxc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rst_state: got=%0d required=0", state_o); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done: got=%b%b required=00", busy, done); end
        checks++; if (dec_start_o !== 1'b0) begin failures++; $display("FAIL rst_dec_start: got=%b required=0", dec_start_o); end
        checks++; if (msg_o !== '0 || q0_0_o !== '0 || q0_1_o !== '0) begin failures++; $display("FAIL rst_data: msg=%h required=0", msg_o); end
        checks++; if (frame_cnt !== '0 || fail_cnt !== '0 || bit_err_cnt !== '0 || timeout_cnt !== '0) begin failures++; $display("FAIL rst_counters: frame=%0d required=0", frame_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        exp_q.delete();
        mode = 2'd0; seed = 32'hACE1_0000; num_frames = '0; dec_timeout = 16'd1000;
        done_en = 1'b1; echo_q0 = 1'b0;
        push_frames(seed, mode, err_base, 3);
        pulse_start();
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (frame_cnt == 32'd2) done_en = 1'b0;
            if (state_o == 3'd5 && frame_cnt == 32'd2) break;
        end
        checks++; if (state_o !== 3'd5) begin failures++; $display("FAIL mid_reach_dec_wait: state=%0d required=5", state_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL mid_rst_state: got=%0d required=0", state_o); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dec_start_o !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl: busy=%b done=%b ds=%b required=0", busy, done, dec_start_o); end
        checks++; if (frame_cnt !== '0) begin failures++; $display("FAIL mid_rst_frame: got=%0d required=0", frame_cnt); end
        checks++; if (q0_0_o !== '0 || q0_1_o !== '0 || msg_o !== '0) begin failures++; $display("FAIL mid_rst_data: q0_0=%h required=0", q0_0_o); end
        @(negedge clk) rst = 1'b0;
        done_en = 1'b1;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_sb_left: got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_mode0_ideal();
        exp_q.delete();
        mode = 2'd0; seed = 32'h1234_5678; num_frames = 32'd4; dec_timeout = 16'd50;
        err_base = {NN{1'b1}}; done_en = 1'b1; echo_q0 = 1'b0;
        push_frames(seed, mode, err_base, 4);
        pulses = 0;
        pulse_start();
        wait_done(4 * 45 + 40, "m0");
        checks++; if (frame_cnt !== 32'd4) begin failures++; $display("FAIL m0_frame: got=%0d required=4", frame_cnt); end
        checks++; if (fail_cnt !== 32'd0) begin failures++; $display("FAIL m0_fail: got=%0d required=0", fail_cnt); end
        checks++; if (bit_err_cnt !== 32'd0) begin failures++; $display("FAIL m0_biterr: got=%0d required=0", bit_err_cnt); end
        checks++; if (timeout_cnt !== 32'd0) begin failures++; $display("FAIL m0_timeout: got=%0d required=0", timeout_cnt); end
        checks++; if (pulses != 4) begin failures++; $display("FAIL m0_pulses: got=%0d required=4", pulses); end
        checks++; if (busy !== 1'b0 || state_o !== 3'd7) begin failures++; $display("FAIL m0_final: busy=%b state=%0d required=0/7", busy, state_o); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL m0_sb_left: got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_mode2_rotate();
        exp_q.delete();
        mode = 2'd2; seed = 32'hDEAD_BEEF; num_frames = 32'd3; dec_timeout = 16'd50;
        err_base = '0; err_base[0] = 1'b1; done_en = 1'b1; echo_q0 = 1'b1;
        push_frames(seed, mode, err_base, 3);
        pulse_start();
        wait_done(3 * 45 + 40, "m2");
        checks++; if (frame_cnt !== 32'd3) begin failures++; $display("FAIL m2_frame: got=%0d required=3", frame_cnt); end
        checks++; if (fail_cnt !== 32'd3) begin failures++; $display("FAIL m2_fail: got=%0d required=3", fail_cnt); end
        checks++; if (bit_err_cnt !== 32'd3) begin failures++; $display("FAIL m2_biterr: got=%0d required=3", bit_err_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL m2_sb_left: got=%0d required=0", exp_q.size()); end
        echo_q0 = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int run;
        exp_q.delete();
        mode = 2'd0; seed = 32'h0BAD_F00D; num_frames = 32'd2; dec_timeout = 16'd10;
        done_en = 1'b0; echo_q0 = 1'b0;
        push_frames(seed, mode, err_base, 2);
        pulse_start();
        n = 0; run = 0;
        while (done !== 1'b1 && n < 2 * 60 + 40) begin
            @(negedge clk);
            n++;
            if (state_o == 3'd5) run++;
            else if (run > 0) begin
                checks++;
                if (run != 10) begin failures++; $display("FAIL to_wait_len: got=%0d required=10", run); end
                run = 0;
            end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL to_done: got=%b required=1", done); end
        checks++; if (timeout_cnt !== 32'd2) begin failures++; $display("FAIL to_count: got=%0d required=2", timeout_cnt); end
        checks++; if (fail_cnt !== 32'd2) begin failures++; $display("FAIL to_fail: got=%0d required=2", fail_cnt); end
        checks++; if (bit_err_cnt !== 32'd416) begin failures++; $display("FAIL to_biterr: got=%0d required=416", bit_err_cnt); end
        checks++; if (frame_cnt !== 32'd2) begin failures++; $display("FAIL to_frame: got=%0d required=2", frame_cnt); end
        done_en = 1'b1;
    endtask

    task automatic test_abort_continuous();
        int n;
        exp_q.delete();
        mode = 2'd0; seed = 32'h5555_AAAA; num_frames = '0; dec_timeout = 16'd50;
        done_en = 1'b1; echo_q0 = 1'b0;
        push_frames(seed, mode, err_base, 6);
        pulse_start();
        n = 0;
        while (n < 6 * 45 + 40) begin
            @(negedge clk);
            n++;
            if (frame_cnt == 32'd5 && state_o == 3'd5) break;
        end
        checks++; if (state_o !== 3'd5 || frame_cnt !== 32'd5) begin failures++; $display("FAIL ab_reach: state=%0d frame=%0d required=5/5", state_o, frame_cnt); end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checks++; if (state_o !== 3'd7) begin failures++; $display("FAIL ab_state: got=%0d required=7", state_o); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ab_flags: done=%b busy=%b required=1/0", done, busy); end
        checks++; if (frame_cnt !== 32'd5) begin failures++; $display("FAIL ab_frame: got=%0d required=5", frame_cnt); end
        checks++; if (fail_cnt !== 32'd0) begin failures++; $display("FAIL ab_fail: got=%0d required=0", fail_cnt); end
        @(negedge clk);
        checks++; if (frame_cnt !== 32'd5 || state_o !== 3'd7) begin failures++; $display("FAIL ab_hold: frame=%0d state=%0d required=5/7", frame_cnt, state_o); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ab_sb_left: got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_seed0_busy_start();
        int n;
        exp_q.delete();
        mode = 2'd1; seed = 32'h0; num_frames = 32'd2; dec_timeout = 16'd50;
        err_base = '0; err_base[NN-1] = 1'b1; err_base[100] = 1'b1; err_base[5] = 1'b1;
        done_en = 1'b1; echo_q0 = 1'b0;
        push_frames(seed, mode, err_base, 2);
        pulse_start();
        n = 0;
        while (state_o != 3'd2 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end
        checks++; if (n != KK) begin failures++; $display("FAIL s0_load_len: got=%0d required=%0d", n, KK); end
        checks++; if (msg_o !== first_msg) begin failures++; $display("FAIL s0_msg: got=%h required=%h", msg_o, first_msg); end
        wait_done(2 * 45 + 40, "s0");
        checks++; if (frame_cnt !== 32'd2) begin failures++; $display("FAIL s0_frame: got=%0d required=2", frame_cnt); end
        checks++; if (fail_cnt !== 32'd0) begin failures++; $display("FAIL s0_fail: got=%0d required=0", fail_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL s0_sb_left: got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; num_frames = '0;
        seed = '0; err_base = '0; dec_timeout = '0; done_en = 1'b1; echo_q0 = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_mode0_ideal();
        test_mode2_rotate();
        test_timeout();
        test_abort_continuous();
        test_seed0_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
